fp32_unpack: RTL
================

# fp32_unpack

Multi-cycle FP32 unpacker and classifier: accepts a packed IEEE-754 binary32 word and produces the unpacked sign / unbiased exponent / significand / class form that the FP32 rounding stage consumes. Subnormals are normalized iteratively; all other classes complete in one cycle. The block sits at the head of the FP datapath, and its outputs feed the arithmetic units whose results re-enter the rounder. Valid/ready handshakes are used on both sides.

## Interface
- TAG_W, 5: width of the sideband tag (rounding mode) carried alongside each operand.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept this cycle.
- in_data  in  32  packed binary32.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  unpacked result present.
- out_ready  in  1  consumer accepts.
- out_sign  out  1  sign bit.
- out_exp  out  10  two's-complement unbiased exponent (1.0 gives 0).
- out_sigPlus  out  25  {fraction[22:0], 2'b00}, with the hidden 1 implicit and guard/sticky zero.
- out_isZero, out_isInf, out_isNaN, out_isSNaN  out  1 each  class flags, mutually exclusive except that isSNaN implies isNaN.
- out_tag  out  TAG_W  registered copy of in_tag.

## Operation
- FSM states: IDLE, NORM, HOLD. Reset enters IDLE.
- in_ready = (IDLE) | (HOLD & out_ready). out_valid = HOLD.
- Accept (in_valid & in_ready): register the sign and tag, and classify from E = in_data[30:23] and F = in_data[22:0].
  - E=255, F≠0: NaN. isSNaN = ~F[22]. out_exp = 10'h080. sig = F. Go to HOLD.
  - E=255, F=0: Inf. out_exp = 10'h080. sig = 0. Go to HOLD.
  - E=0, F=0: Zero. out_exp = 10'h382 (−126). sig = 0. Go to HOLD.
  - E≠0 and E≠255: Normal. out_exp = E − 127, sign-extended to 10 bits. sig = F. Go to HOLD.
  - E=0, F≠0: Subnormal. The working sig is W[23:0] = {1'b0, F}, the working exponent is −126, and the next state is NORM.
- NORM step, once per cycle, on the top nibble W[23:20]:
  - If the nibble is 0: W <<= 4, exp −= 4, stay in NORM.
  - Otherwise: W <<= lzc(nibble), with lzc in 0..3; exp −= lzc; go to HOLD.
  - In HOLD the output sig is W[22:0]; W[23] is guaranteed to be 1 and is dropped.
- Resulting exponent for a subnormal with leading one at F bit k: k − 149, giving a range of −149..−127.
- HOLD with out_ready=1 and in_valid=1 accepts the next operand in the same cycle, giving back-to-back throughput for non-subnormals.
- HOLD with out_ready=0: all outputs remain stable and in_ready=0.
- Exponent arithmetic is 10-bit two's complement and never wraps within the legal range.

## Timing
- Reset values: out_valid=0, in_ready=1 after reset, and all data and flag outputs 0.
- Latency from the accept edge to out_valid:
  - Normal, zero, Inf and NaN: 1 cycle.
  - Subnormal: 1 + N cycles, where N = number of NORM steps = floor((23−k)/4) + 1 when (23−k) mod 4 ≠ 0. Otherwise N = (23−k)/4 + 1, with the final step lzc = 0.
  - Worst case: F=1 gives N=6, so the result is valid 7 cycles after accept.
  - in_ready=0 throughout NORM.
- Reset asserted in any state: the in-flight operand is discarded and the next cycle is IDLE with out_valid=0.
- Outputs come directly from registers; there are no combinational paths from in_* to out_*. in_ready depends combinationally on out_ready.

## Structure
- Package fp32_pkg holds:
  - BIAS=127, EXP_W=10, SIG_W=25;
  - the state enum {IDLE, NORM, HOLD};
  - the class-flag struct {isZero, isInf, isNaN, isSNaN};
  - the constants EXP_SPECIAL=10'h080 and EXP_SUBMIN=10'h382.
- The rounding unit's input port group should be retyped against the same package.
- One sub-module, fp32_unpack_norm_step, is combinational. It takes (W, exp) and returns (W', exp', done), implementing a single NORM step so it can be unit-tested exhaustively.

## Test plan
- in_data=32'h3F800000, out_ready=1:
  - out_valid on cycle +1;
  - sign 0, out_exp 0, sigPlus 0, no class flags.
- in_data=32'h00000001 (smallest subnormal):
  - in_ready=0 for 6 cycles;
  - out_valid at +7 with out_exp=10'h36B (−149) and sigPlus=0.
- in_data=32'h00400000, then 32'h00200000:
  - first result at +2 with exp −127, sig 0;
  - second result at +2 with exp −128, sig 0.
- Specials:
  - 32'h7F800000 gives isInf;
  - 32'hFFC00000 gives isNaN with isSNaN=0, sign 1;
  - 32'h7F800001 gives isNaN and isSNaN with sigPlus=25'h4;
  - 32'h80000000 gives isZero with sign 1.
- Backpressure:
  - hold out_ready=0 for 5 cycles on a normal result: outputs stable and in_ready=0;
  - raise out_ready with in_valid=1: the new operand is accepted in the same cycle and its result appears the next cycle.
- Assert reset during NORM of 32'h00000001:
  - the next cycle shows out_valid=0 and in_ready=1;
  - a subsequent 32'h40000000 yields exp 1, sig 0.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 datapath types: unpacked-format widths, unpacker FSM states and
// class flags consumed by the unpacker and the rounding stage.
package fp32_pkg;
   localparam int BIAS  = 127;
   localparam int EXP_W = 10;
   localparam int SIG_W = 25;

   localparam logic [EXP_W-1:0] EXP_SPECIAL = 10'h080;
   localparam logic [EXP_W-1:0] EXP_SUBMIN  = 10'h382;

   typedef enum logic [1:0] {IDLE, NORM, HOLD} state_e;

   typedef struct packed {
      logic isZero;
      logic isInf;
      logic isNaN;
      logic isSNaN;
   } cls_t;

   // Leading-zero count of a nonzero nibble; an all-zero nibble is handled by the caller.
   function automatic logic [1:0] lzc4(input logic [3:0] n);
      if (n[3])      return 2'd0;
      else if (n[2]) return 2'd1;
      else if (n[1]) return 2'd2;
      else           return 2'd3;
   endfunction
endpackage

// File: rtl/fp32_unpack_if.sv
// Operand-in / unpacked-result-out handshake bundle for fp32_unpack.
interface fp32_unpack_if #(parameter int TAG_W = 5);
   import fp32_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_data;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic                out_sign;
   logic [EXP_W-1:0]    out_exp;
   logic [SIG_W-1:0]    out_sigPlus;
   logic                out_isZero;
   logic                out_isInf;
   logic                out_isNaN;
   logic                out_isSNaN;
   logic [TAG_W-1:0]    out_tag;

   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_sigPlus,
             out_isZero, out_isInf, out_isNaN, out_isSNaN, out_tag
   );

   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_sigPlus,
             out_isZero, out_isInf, out_isNaN, out_isSNaN, out_tag
   );
endinterface

// File: rtl/fp32_unpack_norm_step.sv
// One subnormal normalization step: shift by a whole zero nibble, or finish by
// shifting the leading one into bit 23.
module fp32_unpack_norm_step
   import fp32_pkg::*;
(
   input  logic [23:0]      i_w,
   input  logic [EXP_W-1:0] i_exp,
   output logic [23:0]      o_w,
   output logic [EXP_W-1:0] o_exp,
   output logic             o_done
);
   logic [3:0] w_nib;
   logic [1:0] w_lzc;

   always_comb begin
      w_nib = i_w[23:20];
      w_lzc = lzc4(w_nib);
      if (w_nib == 4'h0) begin
         o_w    = {i_w[19:0], 4'h0};
         o_exp  = i_exp - EXP_W'(4);
         o_done = 1'b0;
      end else begin
         o_w    = i_w << w_lzc;
         o_exp  = i_exp - EXP_W'(w_lzc);
         o_done = 1'b1;
      end
   end
endmodule

// File: rtl/fp32_unpack.sv
// FP32 unpacker/classifier: single-cycle for normals and specials, iterative
// nibble-wise normalization for subnormals, valid/ready on both sides.
module fp32_unpack
   import fp32_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic         clock,
   input  logic         reset,
   fp32_unpack_if.slave bus
);
   state_e            r_state, w_state_nxt;
   logic              r_sign, w_sign_nxt;
   logic [EXP_W-1:0]  r_exp, w_exp_nxt;
   logic [23:0]       r_w, w_w_nxt;
   cls_t              r_cls, w_cls_nxt;
   logic [TAG_W-1:0]  r_tag, w_tag_nxt;

   logic              w_in_ready;
   logic              w_accept;
   logic [7:0]        w_e;
   logic [22:0]       w_f;
   logic [23:0]       w_step_w;
   logic [EXP_W-1:0]  w_step_exp;
   logic              w_step_done;

   fp32_unpack_norm_step u_step (
      .i_w    (r_w),
      .i_exp  (r_exp),
      .o_w    (w_step_w),
      .o_exp  (w_step_exp),
      .o_done (w_step_done)
   );

   assign w_in_ready = (r_state == IDLE) | ((r_state == HOLD) & bus.out_ready);
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_e        = bus.in_data[30:23];
   assign w_f        = bus.in_data[22:0];

   always_comb begin
      w_state_nxt = r_state;
      w_sign_nxt  = r_sign;
      w_exp_nxt   = r_exp;
      w_w_nxt     = r_w;
      w_cls_nxt   = r_cls;
      w_tag_nxt   = r_tag;

      case (r_state)
         IDLE: ;
         NORM: begin
            w_w_nxt   = w_step_w;
            w_exp_nxt = w_step_exp;
            if (w_step_done) w_state_nxt = HOLD;
         end
         HOLD: if (bus.out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      // A new operand in HOLD overrides the drain-to-IDLE above.
      if (w_accept) begin
         w_sign_nxt  = bus.in_data[31];
         w_tag_nxt   = bus.in_tag;
         w_cls_nxt   = '0;
         w_state_nxt = HOLD;
         if (w_e == 8'hFF) begin
            w_exp_nxt = EXP_SPECIAL;
            w_w_nxt   = {1'b0, w_f};
            if (w_f != 23'd0) begin
               w_cls_nxt.isNaN  = 1'b1;
               w_cls_nxt.isSNaN = ~w_f[22];
            end else begin
               w_cls_nxt.isInf  = 1'b1;
            end
         end else if (w_e == 8'h00) begin
            w_exp_nxt = EXP_SUBMIN;
            w_w_nxt   = {1'b0, w_f};
            if (w_f == 23'd0) w_cls_nxt.isZero = 1'b1;
            else              w_state_nxt      = NORM;
         end else begin
            w_exp_nxt = {2'b00, w_e} - EXP_W'(BIAS);
            w_w_nxt   = {1'b1, w_f};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_w     <= '0;
         r_cls   <= '0;
         r_tag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sign  <= w_sign_nxt;
         r_exp   <= w_exp_nxt;
         r_w     <= w_w_nxt;
         r_cls   <= w_cls_nxt;
         r_tag   <= w_tag_nxt;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = (r_state == HOLD);
   assign bus.out_sign    = r_sign;
   assign bus.out_exp     = r_exp;
   assign bus.out_sigPlus = {r_w[22:0], 2'b00};
   assign bus.out_isZero  = r_cls.isZero;
   assign bus.out_isInf   = r_cls.isInf;
   assign bus.out_isNaN   = r_cls.isNaN;
   assign bus.out_isSNaN  = r_cls.isSNaN;
   assign bus.out_tag     = r_tag;
endmodule
